pmem_responder: RTL and testbench



---
 rtl/pmem_responder.sv | 243 ++++++++++++++++++++++++
 tb/tb_pmem_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_responder.sv
// -----------------------------------------------------------------------------
// pmem_responder
//
// Line-granular physical-memory responder that sits below the cache controller
// in place of main memory. It accepts one pmem_read or pmem_write request at a
// time and waits a fixed LATENCY. It then pulses pmem_resp for one cycle,
// returning read data or committing write data to its own line storage.
//
// Each transaction walks IDLE -> BUSY -> RESP -> DONE. The DONE cycle ignores
// requests, so a request the initiator still holds during the RESP cycle is not
// serviced a second time. Back-to-back throughput is one request per LATENCY+2
// cycles.
//
// Optional feature (compile-time macro PMEM_RESPONDER_ERROR_EN):
//   defined   : a line index >= DEPTH_LINES, or read and write both high at
//               acceptance, completes with pmem_error=1. That transaction
//               performs no array write and returns all-zero read data.
//   undefined : pmem_error is tied low, the line index wraps modulo
//               DEPTH_LINES, and read+write together is treated as a read.
//
// Parameters
//   ADDR_WIDTH  : byte-address width
//   LINE_BITS   : line width (32-byte lines; address bits [4:0] are ignored)
//   DEPTH_LINES : number of stored lines
//   LATENCY     : cycles from acceptance to pmem_resp (>= 1)
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   pmem_read    in   line read request, held until pmem_resp
//   pmem_write   in   line write request, held until pmem_resp
//   pmem_address in   byte address of the line
//   pmem_wdata   in   write line data
//   pmem_rdata   out  read line data, valid in the pmem_resp cycle of a read
//   pmem_resp    out  one-cycle completion pulse
//   pmem_error   out  failed access, only ever high together with pmem_resp
//
// Every output is registered. There is no combinational path from an input to
// an output.
// -----------------------------------------------------------------------------
module pmem_responder #(
  parameter int ADDR_WIDTH  = 16,
  parameter int LINE_BITS   = 256,
  parameter int DEPTH_LINES = 64,
  parameter int LATENCY     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic [LINE_BITS-1:0]  pmem_wdata,
  output logic [LINE_BITS-1:0]  pmem_rdata,
  output logic                  pmem_resp,
  output logic                  pmem_error
);

  localparam int IDX_W  = ADDR_WIDTH - 5;
  localparam int MEM_AW = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam int CNT_W  = $clog2(LATENCY + 1);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   op_wr_q, op_wr_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [LINE_BITS-1:0]   wdata_q, wdata_d;
  logic                   err_q, err_d;
  logic                   resp_q, resp_d;
  logic [LINE_BITS-1:0]   rdata_q, rdata_d;
`ifdef PMEM_RESPONDER_ERROR_EN
  logic                   error_q, error_d;
`endif

  logic                   req;
  logic                   accept;
  logic                   req_err;
  logic [IDX_W-1:0]       req_idx;
  logic                   mem_we;

  logic [LINE_BITS-1:0]   mem_q [DEPTH_LINES];

  // Byte-offset bits inside a line carry no information for this memory.
  logic                   unused_offset;
  assign unused_offset = ^pmem_address[4:0];

  // Maps a line index onto a storage slot. With the error feature enabled, an
  // out-of-range index never reaches the array. Without it, the modulo is the
  // intended wrap.
  function automatic logic [MEM_AW-1:0] line_slot(input logic [IDX_W-1:0] idx);
    return MEM_AW'(32'(idx) % $unsigned(DEPTH_LINES));
  endfunction

  assign req     = pmem_read | pmem_write;
  assign accept  = (state_q == IDLE) && req;
  assign req_idx = pmem_address[ADDR_WIDTH-1:5];

`ifdef PMEM_RESPONDER_ERROR_EN
  assign req_err = (pmem_read & pmem_write) |
                   (32'(req_idx) >= $unsigned(DEPTH_LINES));
`else
  assign req_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written only with non-blocking assignments, so
  // every flop samples the pre-edge values of the other flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: each combinational block assigns a default to every signal it drives
  // before any branch, so no path leaves a signal unassigned and no latch is
  // inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req) state_d = (LATENCY > 1) ? BUSY : RESP;
      // The counter was loaded with LATENCY-1. Leaving BUSY on the value 1
      // makes BUSY last LATENCY-1 cycles, so the RESP cycle closes with edge
      // T+LATENCY.
      BUSY: if (cnt_q == CNT_LAST) state_d = RESP;
      RESP: state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transaction latch and latency counter
  // ---------------------------------------------------------------------------
  // The request is captured once, at acceptance. From then on the transaction
  // completes from these copies, even if the initiator drops its request.
  always_comb begin
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (accept) begin
      op_wr_d = pmem_write & ~pmem_read;
      idx_d   = req_idx;
      wdata_d = pmem_wdata;
      err_d   = req_err;
      cnt_d   = CNT_LOAD;
    end else if (state_q == BUSY) begin
      cnt_d   = cnt_q - 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  // The outputs are registered, so they are computed from the state being
  // entered. The transaction fields are taken from the *_d copies. With
  // LATENCY=1, IDLE goes straight to RESP, and the fields are only being
  // latched on that same edge.
  always_comb begin
    resp_d  = (state_d == RESP);
    rdata_d = rdata_q;
    if (state_d == RESP && !op_wr_d) begin
      rdata_d = err_d ? '0 : mem_q[line_slot(idx_d)];
    end
  end

`ifdef PMEM_RESPONDER_ERROR_EN
  always_comb begin
    error_d = (state_d == RESP) & err_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef PMEM_RESPONDER_ERROR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end
  assign pmem_error = error_q;
`else
  assign pmem_error = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Line storage
  // ---------------------------------------------------------------------------
  // A write commits at the edge that closes its RESP cycle, which comes before
  // any later acceptance. A read that follows therefore sees the new data.
  // Reset forces state_q to IDLE, so a transaction interrupted by reset never
  // writes.
  assign mem_we = (state_q == RESP) & op_wr_q & ~err_q;

  // NOTE: the array is deliberately left out of reset. It maps onto plain
  // storage, and never-written lines read back as X.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[line_slot(idx_q)] <= wdata_q;
    end
  end

  assign pmem_rdata = rdata_q;
  assign pmem_resp  = resp_q;

endmodule

// File: tb/tb_pmem_responder.sv
// -----------------------------------------------------------------------------
// tb_pmem_responder
//
// Scoreboard bench for pmem_responder with default parameters (LATENCY=4).
// The driver issues each request. At the same moment it pushes the expected
// response into a queue: read data, error flag, and the cycle in which
// pmem_resp must appear. A separate monitor samples the DUT on the falling
// edge. Whenever pmem_resp is high, the monitor pops the queue and compares.
// A pulse with nothing queued is reported as an unexpected response.
//
// Cycle bookkeeping: cyc counts rising edges. A request accepted at edge A
// must show pmem_resp at the falling edge where cyc == A+LAT-1, which is the
// cycle closed by edge A+LAT. The next acceptance can come no earlier than
// edge R+3, where R is the cyc value of the response.
// -----------------------------------------------------------------------------
module tb_pmem_responder;

  localparam int LAT = 4;
  localparam int LB  = 256;

  localparam logic [LB-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [LB-1:0] PAT_X  = {4{64'h0123_4567_89AB_CDEF}};
  localparam logic [LB-1:0] PAT_C3 = {32{8'hC3}};
  localparam logic [LB-1:0] PAT_L0 = {16{16'h5A0F}};
  localparam logic [LB-1:0] PAT_11 = {32{8'h11}};
  localparam logic [LB-1:0] PAT_EE = {32{8'hEE}};
  localparam logic [LB-1:0] PAT_FF = {LB{1'b1}};

  logic          clk;
  logic          rst_n;
  logic          pmem_read;
  logic          pmem_write;
  logic [15:0]   pmem_address;
  logic [LB-1:0] pmem_wdata;
  logic [LB-1:0] pmem_rdata;
  logic          pmem_resp;
  logic          pmem_error;

  typedef struct {
    logic [LB-1:0] rdata;
    logic          err;
    int            cyc;
    string         name;
  } exp_t;

  exp_t          sb_q[$];
  int            cyc        = 0;
  int            ready_edge = 0;
  int            n_checks   = 0;
  int            n_errors   = 0;
  logic [LB-1:0] last_rd    = '0;

  pmem_responder #(
    .ADDR_WIDTH  (16),
    .LINE_BITS   (LB),
    .DEPTH_LINES (64),
    .LATENCY     (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .pmem_error   (pmem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [LB-1:0] got,
                       input logic [LB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every response pulse is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (pmem_resp === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_resp: pmem_resp high at cycle %0d with nothing outstanding", cyc);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_cycle"}, LB'(cyc), LB'(e.cyc));
        check({e.name, "_rdata"}, pmem_rdata, e.rdata);
        check({e.name, "_error"}, LB'(pmem_error), LB'(e.err));
      end
    end
  end

  // Issues one request at a falling edge, queues its expectation, and holds
  // the request until the response pulse (bounded).
  task automatic do_req(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [LB-1:0] wd, input logic [LB-1:0] exp_rd,
                        input logic exp_err, input string name);
    exp_t e;
    int   a;
    int   waited;
    a = (cyc + 1 >= ready_edge) ? cyc + 1 : ready_edge;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wd;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.cyc   = a + LAT - 1;
    e.name  = name;
    sb_q.push_back(e);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (pmem_resp !== 1'b1 && waited < 40);
    if (pmem_resp !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_timeout: no pmem_resp within %0d cycles", name, waited);
    end else begin
      ready_edge = cyc + 3;
    end
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
  endtask

  task automatic wr_line(input logic [15:0] addr, input logic [LB-1:0] d,
                         input string name);
    // Writes leave pmem_rdata at the last read value.
    do_req(1'b0, 1'b1, addr, d, last_rd, 1'b0, name);
  endtask

  task automatic rd_line(input logic [15:0] addr, input logic [LB-1:0] exp,
                         input logic exp_err, input string name);
    last_rd = exp;
    do_req(1'b1, 1'b0, addr, '0, exp, exp_err, name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int waited;
    exp_t e;

    rst_n        = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    repeat (3) @(negedge clk);
    check("reset_resp",  LB'(pmem_resp),  '0);
    check("reset_error", LB'(pmem_error), '0);
    check("reset_rdata", pmem_rdata,      '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read of the same line returns the new data.
    wr_line(16'h0040, PAT_A5, "wr_a5");
    rd_line(16'h0040, PAT_A5, 1'b0, "rd_a5");

    // Offset bits [4:0] are ignored: 0x005F lies in the same line as 0x0040.
    wr_line(16'h0040, PAT_X, "wr_x");
    rd_line(16'h005F, PAT_X, 1'b0, "rd_x_offset");

    // Neighbouring lines are independent.
    wr_line(16'h0060, PAT_C3, "wr_c3");
    rd_line(16'h0040, PAT_X,  1'b0, "rd_x_again");
    rd_line(16'h0060, PAT_C3, 1'b0, "rd_c3");

    // Held read: hold through edge a+LAT+2, giving exactly two pulses, the
    // second from the re-acceptance at edge a+LAT+2.
    a = (cyc + 1 >= ready_edge) ? cyc + 1 : ready_edge;
    pmem_read    = 1'b1;
    pmem_address = 16'h0040;
    e.rdata = PAT_X; e.err = 1'b0; e.cyc = a + LAT - 1;     e.name = "held_first";
    sb_q.push_back(e);
    e.rdata = PAT_X; e.err = 1'b0; e.cyc = a + 2 * LAT + 1; e.name = "held_second";
    sb_q.push_back(e);
    while (cyc < a + LAT + 2) @(negedge clk);
    pmem_read = 1'b0;
    waited = 0;
    while (sb_q.size() != 0 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    check("held_outstanding", LB'(sb_q.size()), '0);
    last_rd    = PAT_X;
    ready_edge = a + 2 * LAT + 4;
    repeat (3) @(negedge clk);

    // Index 64: out of range with the error feature, otherwise wraps to line 0.
    wr_line(16'h0000, PAT_L0, "wr_l0");
`ifdef PMEM_RESPONDER_ERROR_EN
    rd_line(16'h0800, '0, 1'b1, "rd_idx64");
    // Read+write together is an error: zero data and no commit.
    last_rd = '0;
    do_req(1'b1, 1'b1, 16'h0060, PAT_EE, '0, 1'b1, "rdwr_both");
`else
    rd_line(16'h0800, PAT_L0, 1'b0, "rd_idx64");
    // Read+write together is treated as a plain read.
    last_rd = PAT_C3;
    do_req(1'b1, 1'b1, 16'h0060, PAT_EE, PAT_C3, 1'b0, "rdwr_both");
`endif
    rd_line(16'h0060, PAT_C3, 1'b0, "rd_c3_unchanged");

    // Reset during the BUSY phase of a write drops the write entirely.
    wr_line(16'h0080, PAT_11, "wr_11");
    while (cyc + 1 < ready_edge) @(negedge clk);
    pmem_write   = 1'b1;
    pmem_address = 16'h0080;
    pmem_wdata   = PAT_FF;
    @(negedge clk);
    pmem_write = 1'b0;
    rst_n      = 1'b0;
    #1;
    check("midrst_resp",  LB'(pmem_resp),  '0);
    check("midrst_error", LB'(pmem_error), '0);
    check("midrst_rdata", pmem_rdata,      '0);
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    ready_edge = 0;
    last_rd    = '0;
    repeat (6) @(negedge clk);
    rd_line(16'h0080, PAT_11, 1'b0, "rd_after_reset");

    repeat (4) @(negedge clk);
    check("final_outstanding", LB'(sb_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
